parking_meter_gen: RTL and testbench

Parametrised successor to the four-button parking meter. It holds a remaining-time count in seconds and decrements it once per prescaled tick. It accepts edge-detected add-time and preset inputs, converts the count to BCD with a sequential double-dabble engine, and drives a DIGITS-wide multiplexed seven-segment display. The display blinks at two rates: one for the low-time warning and one for expiry. It sits between debounced board buttons and the display pins.

---
 rtl/parking_meter_gen.sv | 216 +++++++++++++++++++++
 tb/tb_parking_meter_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_meter_gen.sv
// parking_meter_gen
//   Remaining-time parking meter. Holds a binary seconds count that is
//   decremented once per prescaled tick, adds or presets time on rising
//   edges of the button inputs, converts the count to BCD with a serial
//   double-dabble engine and scans a multiplexed seven-segment display
//   that blinks slowly while time is low and quickly once it has expired.
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   add      level inputs; each rising edge of add[i] adds ADDi seconds
//   preset   level inputs; a rising edge loads PRESET1 (priority) or PRESET0
//   led_seg  active-low segments {g,f,e,d,c,b,a} of the selected digit
//   an       active-low one-hot digit enable, an[0] = least-significant digit
//   val      BCD of the last converted time, digit i at [4i+3:4i]
//   expired  time == 0 (registered)
//   low      0 < time < LOW_TIME (registered)
module parking_meter_gen #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned SCAN_DIV = 250,
  parameter int unsigned ADD0     = 60,
  parameter int unsigned ADD1     = 120,
  parameter int unsigned ADD2     = 180,
  parameter int unsigned ADD3     = 300,
  parameter int unsigned PRESET0  = 15,
  parameter int unsigned PRESET1  = 150,
  parameter int unsigned LOW_TIME = 180
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            add,
  input  logic [1:0]            preset,
  output logic [6:0]            led_seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   val,
  output logic                  expired,
  output logic                  low
);

  localparam int unsigned MAX_TIME = 10**DIGITS - 1;
  localparam int TW = $clog2(MAX_TIME + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(TW + 1);
  localparam int BW = 4 * DIGITS;

  // ---------------------------------------------------------------- edges
  logic [3:0] add_s_q, add_p_q;
  logic [1:0] pre_s_q, pre_p_q;
  logic [3:0] add_rise;
  logic [1:0] pre_rise;

  assign add_rise = add_s_q & ~add_p_q;
  assign pre_rise = pre_s_q & ~pre_p_q;

  // ------------------------------------------------------ time / prescaler
  logic [TW-1:0] time_q, time_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick;
  logic [31:0]   sum;
  logic          expired_q, low_q, sec_q;
  logic          half, blank;

  always_comb begin
    sum = 32'(time_q);
    if (add_rise[0]) sum = sum + ADD0;
    if (add_rise[1]) sum = sum + ADD1;
    if (add_rise[2]) sum = sum + ADD2;
    if (add_rise[3]) sum = sum + ADD3;
    if (sum > MAX_TIME) sum = MAX_TIME;

    tick   = 1'b0;
    pcnt_d = pcnt_q + 1'b1;
    time_d = TW'(sum);
    // A preset swallows adds and the tick, and realigns the prescaler so the
    // next decrement is a full second away.
    if (|pre_rise) begin
      time_d = pre_rise[1] ? TW'(PRESET1) : TW'(PRESET0);
      pcnt_d = '0;
    end else if (pcnt_q == PW'(TICK_DIV - 1)) begin
      tick   = 1'b1;
      pcnt_d = '0;
      time_d = (sum != 0) ? TW'(sum - 1) : '0;
    end
  end

  // First half of each second is the visible phase of the expiry blink.
  assign half  = (pcnt_q < PW'(TICK_DIV / 2));
  assign blank = expired_q ? ~half : (low_q & ~sec_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_s_q   <= '0;
      add_p_q   <= '0;
      pre_s_q   <= '0;
      pre_p_q   <= '0;
      time_q    <= '0;
      pcnt_q    <= '0;
      sec_q     <= 1'b0;
      expired_q <= 1'b1;
      low_q     <= 1'b0;
    end else begin
      add_s_q   <= add;
      add_p_q   <= add_s_q;
      pre_s_q   <= preset;
      pre_p_q   <= pre_s_q;
      time_q    <= time_d;
      pcnt_q    <= pcnt_d;
      if (tick) sec_q <= ~sec_q;
      expired_q <= (time_q == '0);
      low_q     <= (time_q != '0) && (32'(time_q) < LOW_TIME);
    end
  end

  // ------------------------------------------------- double-dabble engine
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_st_e;

  bcd_st_e       st_q;
  logic [TW-1:0] last_q, cap_q, bin_q;
  logic [BW-1:0] bcd_q, bcd_adj, val_q;
  logic [CW-1:0] it_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // A time change mid-conversion is not chased; the IDLE compare against
  // last_q picks it up once the current result has been written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      last_q <= '0;
      cap_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      it_q   <= '0;
      val_q  <= '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (time_q != last_q) begin
            cap_q <= time_q;
            bin_q <= time_q;
            bcd_q <= '0;
            it_q  <= '0;
            st_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          it_q           <= it_q + 1'b1;
          if (it_q == CW'(TW - 1)) st_q <= S_DONE;
        end
        S_DONE: begin
          val_q  <= bcd_q;
          last_q <= cap_q;
          st_q   <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- display
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h40;
      4'd1:    seg_enc = 7'h79;
      4'd2:    seg_enc = 7'h24;
      4'd3:    seg_enc = 7'h30;
      4'd4:    seg_enc = 7'h19;
      4'd5:    seg_enc = 7'h12;
      4'd6:    seg_enc = 7'h02;
      4'd7:    seg_enc = 7'h78;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h10;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  logic [SW-1:0]     scnt_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic [3:0]        cur_dig;

  assign cur_dig = val_q[4*idx_q +: 4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
    end else begin
      if (scnt_q == SW'(SCAN_DIV - 1)) begin
        scnt_q <= '0;
        idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scnt_q <= scnt_q + 1'b1;
      end
      an_q  <= blank ? '1 : ~(DIGITS'(1) << idx_q);
      seg_q <= seg_enc(cur_dig);
    end
  end

  assign led_seg = seg_q;
  assign an      = an_q;
  assign val     = val_q;
  assign expired = expired_q;
  assign low     = low_q;

endmodule

// File: tb/tb_parking_meter_gen.sv
// Bench for parking_meter_gen with a short prescaler (TICK_DIV=64) and scan
// (SCAN_DIV=4). Reset release is done on a falling edge at cycle r0, so the
// first tick lands on rising edge r0+64; a button driven at cycle c moves
// time at edge c+2 and val at edge c+18.
module tb_parking_meter_gen;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 64;
  localparam int SCAN_DIV = 4;
  localparam int K_VAL = 0, K_EXP = 1, K_LOW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  add = '0;
  logic [1:0]  preset = '0;
  logic [6:0]  led_seg;
  logic [3:0]  an;
  logic [15:0] val;
  logic        expired, low;

  parking_meter_gen #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .add(add), .preset(preset),
    .led_seg(led_seg), .an(an), .val(val), .expired(expired), .low(low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // ------------------------------------------------------------ scoreboard
  typedef struct { string nm; int kind; logic [31:0] exp; int due; } sb_t;
  sb_t sb[$];

  function automatic void push(input string nm, input int kind, input logic [31:0] e, input int due);
    sb_t t;
    t.nm = nm; t.kind = kind; t.exp = e; t.due = due;
    sb.push_back(t);
  endfunction

  always @(negedge clk) begin : mon
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_VAL:   chk(sb[i].nm, 32'(val), sb[i].exp);
          K_EXP:   chk(sb[i].nm, 32'(expired), sb[i].exp);
          default: chk(sb[i].nm, 32'(low), sb[i].exp);
        endcase
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // --------------------------------------------------------------- helpers
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'd0: on = 7'h3F; 4'd1: on = 7'h06; 4'd2: on = 7'h5B; 4'd3: on = 7'h4F;
      4'd4: on = 7'h66; 4'd5: on = 7'h6D; 4'd6: on = 7'h7D; 4'd7: on = 7'h07;
      4'd8: on = 7'h7F; 4'd9: on = 7'h6F; default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] a, input logic [1:0] p, input int at);
    wait_cyc(at);
    add = a; preset = p;
    wait_cyc(at + 1);
    add = '0; preset = '0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 3000) begin @(negedge clk); g++; end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input bit chk_state, output int r0);
    @(negedge clk);
    rst = 1'b0; add = '0; preset = '0;
    repeat (3) @(negedge clk);
    if (chk_state) begin
      chk("rst_val", 32'(val), 32'h0);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(led_seg), 32'h7F);
      chk("rst_expired", 32'(expired), 32'h1);
      chk("rst_low", 32'(low), 32'h0);
    end
    rst = 1'b1;
    r0 = cyc;
  endtask

  task automatic measure_blink(input int from_c, input int to_c, output int period, output int on_len);
    int  last;
    bit  prev, b;
    last = -1; period = -1; on_len = -1;
    wait_cyc(from_c);
    prev = (an == 4'hF);
    while (cyc < to_c) begin
      @(negedge clk);
      b = (an == 4'hF);
      if (b && !prev) begin
        if (last >= 0) period = cyc - last;
        last = cyc;
      end
      if (!b && prev && last >= 0) on_len = cyc - last;
      prev = b;
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [3:0]  a1; logic [1:0] p1;
    logic [3:0]  a2; logic [1:0] p2;
    logic [15:0] eval; logic eexp; logic elow;
  } vec_t;
  vec_t vecs[12];

  initial begin : main
    int r0, r1, per, onl, idx;
    bit ok;
    logic [3:0] seen;

    vecs[0]  = '{4'b0001, 2'b00, 4'b0000, 2'b00, 16'h0060, 1'b0, 1'b1};
    vecs[1]  = '{4'b1001, 2'b00, 4'b0000, 2'b00, 16'h0360, 1'b0, 1'b0};
    vecs[2]  = '{4'b0010, 2'b00, 4'b0100, 2'b00, 16'h0300, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 2'b01, 4'b0000, 2'b00, 16'h0015, 1'b0, 1'b1};
    vecs[4]  = '{4'b0000, 2'b11, 4'b0000, 2'b00, 16'h0150, 1'b0, 1'b1};
    vecs[5]  = '{4'b0010, 2'b10, 4'b0000, 2'b00, 16'h0150, 1'b0, 1'b1};
    vecs[6]  = '{4'b1111, 2'b00, 4'b0000, 2'b00, 16'h0660, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 2'b00, 4'b0000, 2'b01, 16'h0015, 1'b0, 1'b1};
    vecs[8]  = '{4'b0000, 2'b10, 4'b1000, 2'b00, 16'h0450, 1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 2'b00, 4'b0000, 2'b00, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{4'b0100, 2'b00, 4'b0000, 2'b00, 16'h0180, 1'b0, 1'b0};
    vecs[11] = '{4'b0000, 2'b01, 4'b0100, 2'b00, 16'h0195, 1'b0, 1'b0};

    // Reset state, then single add with exact conversion latency and 5 ticks.
    do_reset(1'b1, r0);
    push("A_exp_before", K_EXP, 1, r0 + 4);
    push("A_exp_after", K_EXP, 0, r0 + 5);
    push("A_low", K_LOW, 1, r0 + 5);
    push("A_val_early", K_VAL, 32'h0000, r0 + 19);
    push("A_val_60", K_VAL, 32'h0060, r0 + 20);
    push("A_val_56", K_VAL, 32'h0056, r0 + 335);
    push("A_val_55", K_VAL, 32'h0055, r0 + 336);
    pulse(4'b0001, 2'b00, r0 + 2);
    drain();

    // Table vectors, each from a fresh reset and settled before the first tick.
    foreach (vecs[v]) begin
      do_reset(1'b0, r0);
      push($sformatf("V%0d_val", v), K_VAL, 32'(vecs[v].eval), r0 + 40);
      push($sformatf("V%0d_exp", v), K_EXP, 32'(vecs[v].eexp), r0 + 40);
      push($sformatf("V%0d_low", v), K_LOW, 32'(vecs[v].elow), r0 + 40);
      pulse(vecs[v].a1, vecs[v].p1, r0 + 2);
      pulse(vecs[v].a2, vecs[v].p2, r0 + 4);
      drain();
      if (!vecs[v].eexp && !vecs[v].elow) begin
        ok = 1'b1; seen = '0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if ($countones(~an) != 1) ok = 1'b0;
          else begin
            idx = 0;
            for (int j = 0; j < DIGITS; j++) if (!an[j]) idx = j;
            seen = seen | ~an;
            if (led_seg !== enc(vecs[v].eval[idx*4 +: 4])) ok = 1'b0;
          end
        end
        chk($sformatf("V%0d_scan", v), {27'b0, ok, seen}, 32'h1F);
      end
    end

    // Saturation at 9999, extra add stays clamped, then 9990 + 300 clamps.
    do_reset(1'b0, r0);
    push("C_val_sat", K_VAL, 32'h9999, r0 + 110);
    push("C_low", K_LOW, 0, r0 + 110);
    push("C_exp", K_EXP, 0, r0 + 110);
    push("C_val_add2", K_VAL, 32'h9999, r0 + 126);
    push("C_val_9990", K_VAL, 32'h9990, r0 + 680);
    push("C_val_pre", K_VAL, 32'h9990, r0 + 699);
    push("C_val_clamp", K_VAL, 32'h9999, r0 + 700);
    for (int k = 0; k < 35; k++) pulse(4'b1000, 2'b00, r0 + 2 + 2*k);
    pulse(4'b0100, 2'b00, r0 + 112);
    pulse(4'b1000, 2'b00, r0 + 682);
    drain();

    // Preset colliding with add and tick; preset away from a tick restarts prescaler.
    do_reset(1'b0, r0);
    push("D_val_150", K_VAL, 32'h0150, r0 + 120);
    push("D_val_hold", K_VAL, 32'h0150, r0 + 143);
    push("D_val_149", K_VAL, 32'h0149, r0 + 144);
    push("D_val_both", K_VAL, 32'h0150, r0 + 220);
    push("D_val_hold2", K_VAL, 32'h0150, r0 + 241);
    push("D_val_149b", K_VAL, 32'h0149, r0 + 242);
    pulse(4'b0010, 2'b10, r0 + 62);
    pulse(4'b0000, 2'b11, r0 + 160);
    drain();

    // Countdown from 15: slow blink while low, fast blink and hold at 0.
    do_reset(1'b0, r0);
    push("E_val_15", K_VAL, 32'h0015, r0 + 40);
    push("E_low_on", K_LOW, 1, r0 + 964);
    push("E_exp_off", K_EXP, 0, r0 + 964);
    push("E_low_off", K_LOW, 0, r0 + 965);
    push("E_exp_on", K_EXP, 1, r0 + 965);
    push("E_val_0", K_VAL, 32'h0000, r0 + 1000);
    push("E_val_hold0", K_VAL, 32'h0000, r0 + 1410);
    push("E_exp_hold", K_EXP, 1, r0 + 1410);
    pulse(4'b0000, 2'b01, r0 + 2);
    measure_blink(r0 + 100, r0 + 700, per, onl);
    chk("E_low_period", 32'(per), 32'(2*TICK_DIV));
    chk("E_low_blank", 32'(onl), 32'(TICK_DIV));
    measure_blink(r0 + 1000, r0 + 1400, per, onl);
    chk("E_exp_period", 32'(per), 32'(TICK_DIV));
    chk("E_exp_blank", 32'(onl), 32'(TICK_DIV/2));
    drain();

    // Held input adds once; a fresh press adds again.
    do_reset(1'b0, r0);
    push("F_held", K_VAL, 32'h0060, r0 + 40);
    push("F_repress", K_VAL, 32'h0120, r0 + 55);
    wait_cyc(r0 + 2); add = 4'b0001;
    wait_cyc(r0 + 22); add = '0;
    pulse(4'b0001, 2'b00, r0 + 30);
    drain();

    // Reset in the middle of a conversion.
    do_reset(1'b0, r0);
    pulse(4'b0001, 2'b00, r0 + 2);
    wait_cyc(r0 + 10);
    rst = 1'b0;
    #1;
    chk("G_val_in_rst", 32'(val), 32'h0);
    chk("G_an_in_rst", 32'(an), 32'hF);
    chk("G_seg_in_rst", 32'(led_seg), 32'h7F);
    chk("G_exp_in_rst", 32'(expired), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    r1 = cyc;
    push("G_val_after", K_VAL, 32'h0000, r1 + 30);
    push("G_exp_after", K_EXP, 1, r1 + 30);
    push("G_low_after", K_LOW, 0, r1 + 30);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at cycle %0d, required finish before 100000", cyc);
    $fatal(1);
  end

endmodule
